// File: rtl/ifetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Used by ifetch_queue (top) and ifq_fifo.
package ifetch_queue_pkg;

    localparam int XLEN_MSB = 31;
    localparam int XLEN_LSB = 0;

    localparam logic [XLEN_MSB:XLEN_LSB] IFQ_RESET_PC = 32'h0000_0000;
    localparam int                       IFQ_DEPTH    = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } ifq_state_t;

    typedef struct packed {
        logic [XLEN_MSB:XLEN_LSB] pc;
        logic [XLEN_MSB:XLEN_LSB] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, instr} entries; pointers carry a wrap bit so
// full and empty are distinguishable. Flush discards all entries.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter  int DEPTH = IFQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  ifq_entry_t i_data,
    output ifq_entry_t o_data,
    output logic       o_empty,
    output logic [AW:0] o_count
);

    ifq_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    // A push and pop on a full buffer write the slot being popped; the head
    // is read combinationally before the edge, so nothing is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential prefetch into a small queue, redirect flush.
// Define IFQ_BYPASS_EN to forward a response straight to the decoder when the queue is empty.
//
//  state | meaning
//  FETCH | may issue a request at fetch_pc when a queue slot is free
//  WAIT  | one request granted, response will be queued
//  DROP  | one response still owed from before a redirect, to be discarded
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    ifq_state_t    r_state;
    ifq_state_t    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_req_pc;
    logic          r_run;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;
    logic          w_bypass;
    logic [CW-1:0] w_count;
    ifq_entry_t    w_head;
    ifq_entry_t    w_push_entry;

    // r_run holds mem_req low for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_run      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_run      <= 1'b1;
            if (mem_req && mem_gnt) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // Nothing is outstanding in FETCH, so queue occupancy alone gates a request.
    assign mem_req  = r_run && (r_state == FETCH) && !redirect_valid && (w_count < DEPTH_C);
    assign mem_addr = r_fetch_pc;

`ifdef IFQ_BYPASS_EN
    assign w_bypass    = w_fifo_empty && mem_rvalid && (r_state == WAIT) && !redirect_valid;
    assign instr_valid = w_bypass || !w_fifo_empty;
    assign instr_data  = w_bypass ? mem_rdata : w_head.instr;
    assign instr_pc    = w_bypass ? r_req_pc  : w_head.pc;
`else
    assign w_bypass    = 1'b0;
    assign instr_valid = !w_fifo_empty;
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;
`endif

    assign w_pop = !w_fifo_empty && instr_ready && !redirect_valid;

    always_comb begin
        w_state_nxt        = r_state;
        w_fetch_pc_nxt     = r_fetch_pc;
        w_push             = 1'b0;
        w_push_entry.pc    = r_req_pc;
        w_push_entry.instr = mem_rdata;
        if (redirect_valid) begin
            w_fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
            // A response arriving now settles the debt; otherwise one is still owed.
            if (((r_state != FETCH) && !mem_rvalid) || ((r_state == FETCH) && mem_gnt)) begin
                w_state_nxt = DROP;
            end else begin
                w_state_nxt = FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_req && mem_gnt) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        w_state_nxt    = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        w_push      = !(w_bypass && instr_ready);
                        w_state_nxt = FETCH;
                    end
                end
                DROP: begin
                    if (mem_rvalid) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a memory responder plus a reference model
// of queue contents, fetch address and delivered instruction stream order.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // reference model
    logic [31:0] mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_stream_pc;
    logic [31:0] m_out_pc;
    bit          m_out;
    bit          m_stale;
    int          n_consumed = 0;

    // memory responder
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_pc;

    // stimulus knobs (percent) and max extra response latency
    int p_gnt, p_ready, p_redir, max_lat;

    task automatic model_reset();
        mq.delete();
        m_fetch_pc  = RESET_PC;
        m_stream_pc = RESET_PC;
        m_out       = 0;
        m_stale     = 0;
        mem_busy    = 0;
        mem_wait    = 0;
    endtask

    task automatic drive();
        redirect_valid = ($urandom_range(99) < p_redir);
        if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
        else                        redirect_pc = $urandom;
        instr_ready = ($urandom_range(99) < p_ready);
        mem_gnt     = !redirect_valid && ($urandom_range(99) < p_gnt);
        if (mem_busy && mem_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_at(mem_pc);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_busy) mem_wait--;
        end
    endtask

    task automatic check_update();
        bit          byp;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] head;
        byp  = 0;
        head = '0;
`ifdef IFQ_BYPASS_EN
        byp = (mq.size() == 0) && mem_rvalid && m_out && !m_stale && !redirect_valid;
`endif
        exp_req = !m_out && !redirect_valid && (mq.size() < DEPTH);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", mem_addr, m_fetch_pc);
        exp_valid = byp || (mq.size() > 0);
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            head = byp ? m_out_pc : mq[0];
            check("instr_pc", instr_pc, head);
            check("instr_data", instr_data, word_at(head));
        end

        if (redirect_valid) begin
            mq.delete();
            m_fetch_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_stream_pc = m_fetch_pc;
            if (m_out && !mem_rvalid) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
        end else begin
            if (exp_valid && instr_ready) begin
                check("stream_pc", instr_pc, m_stream_pc);
                m_stream_pc += 32'd4;
                n_consumed++;
                if (!byp) void'(mq.pop_front());
            end
            if (mem_rvalid) begin
                if (m_out && !m_stale && !(byp && instr_ready)) mq.push_back(m_out_pc);
                m_out   = 0;
                m_stale = 0;
            end
            if (exp_req && mem_gnt) begin
                m_out      = 1;
                m_stale    = 0;
                m_out_pc   = m_fetch_pc;
                m_fetch_pc += 32'd4;
            end
        end

        if (mem_rvalid) mem_busy = 0;
        if (mem_req && mem_gnt) begin
            mem_busy = 1;
            mem_wait = $urandom_range(max_lat);
            mem_pc   = mem_addr;
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            check_update();
        end
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        do_reset();

        // streaming: immediate grant, one-cycle response, decoder always ready
        p_gnt = 100; p_ready = 100; p_redir = 0; max_lat = 0;
        run(16);
        // decoder stalled: fetch must stop at DEPTH words, then drain in order
        p_ready = 0;
        run(20);
        p_ready = 100;
        run(20);
        // grant withheld: request and address must hold
        p_gnt = 0;
        run(5);
        p_gnt = 100;
        run(10);
        // random traffic with redirects
        p_gnt = 60; p_ready = 60; p_redir = 8; max_lat = 3;
        run(3000);
        // reset mid-transaction, then more random traffic
        @(negedge clk);
        do_reset();
        p_gnt = 70; p_ready = 50; p_redir = 5; max_lat = 2;
        run(1500);

        check("progress", 32'(n_consumed > 200), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
